// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one uart_tx among N_REQ requesters: grants one
// frame at a time, drives uart_tx in/start, and reports done or start-timeout.
module uart_tx_arbiter #(
    parameter int unsigned N_REQ         = 4,
    parameter int unsigned DATA_W        = 8,
    parameter int unsigned START_TIMEOUT = 64,
    parameter int unsigned GUARD_CYCLES  = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
    output logic [N_REQ-1:0]          grant,
    output logic [N_REQ-1:0]          done,
    output logic [N_REQ-1:0]          err,
    output logic [DATA_W-1:0]         tx_in,
    output logic                      tx_start,
    input  logic                      tx_busy,
    output logic                      active,
    output logic [$clog2(N_REQ)-1:0]  owner
);

    localparam int unsigned OW   = $clog2(N_REQ);
    localparam int unsigned CMAX = (START_TIMEOUT > GUARD_CYCLES) ? START_TIMEOUT : GUARD_CYCLES;
    localparam int unsigned CW   = $clog2(CMAX + 1);

    typedef enum logic [1:0] {IDLE, LAUNCH, DRAIN, GAP} state_e;

    state_e              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [OW-1:0]       rr_q, rr_d;
    logic [OW-1:0]       owner_q, owner_d;
    logic [DATA_W-1:0]   tx_in_q, tx_in_d;
    logic                tx_start_q, tx_start_d;
    logic [N_REQ-1:0]    grant_q, grant_d;
    logic [N_REQ-1:0]    done_q, done_d;
    logic [N_REQ-1:0]    err_q, err_d;

    logic                found;
    logic [OW-1:0]       sel;

    // First set request at or after rr_q, wrapping explicitly for non-power-of-2 N_REQ.
    always_comb begin : sel_search
        int unsigned idx;
        found = 1'b0;
        sel   = '0;
        idx   = 0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            idx = int'(rr_q) + k;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (!found && req[idx]) begin
                found = 1'b1;
                sel   = OW'(idx);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rr_d       = rr_q;
        owner_d    = owner_q;
        tx_in_d    = tx_in_q;
        tx_start_d = tx_start_q;
        grant_d    = '0;
        done_d     = '0;
        err_d      = '0;
        unique case (state_q)
            IDLE: begin
                if (found && !tx_busy) begin
                    grant_d[sel] = 1'b1;
                    tx_in_d      = req_data[int'(sel)*DATA_W +: DATA_W];
                    owner_d      = sel;
                    rr_d         = (sel == OW'(N_REQ-1)) ? '0 : sel + 1'b1;
                    tx_start_d   = 1'b1;
                    cnt_d        = '0;
                    state_d      = LAUNCH;
                end
            end
            LAUNCH: begin
                // busy wins over a coincident terminal count
                if (tx_busy) begin
                    tx_start_d = 1'b0;
                    state_d    = DRAIN;
                end else if (cnt_q == CW'(START_TIMEOUT-1)) begin
                    tx_start_d     = 1'b0;
                    err_d[owner_q] = 1'b1;
                    cnt_d          = '0;
                    state_d        = (GUARD_CYCLES == 0) ? IDLE : GAP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DRAIN: begin
                if (!tx_busy) begin
                    done_d[owner_q] = 1'b1;
                    cnt_d           = '0;
                    state_d         = (GUARD_CYCLES == 0) ? IDLE : GAP;
                end
            end
            GAP: begin
                if (cnt_q == CW'(GUARD_CYCLES-1)) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            rr_q       <= '0;
            owner_q    <= '0;
            tx_in_q    <= '0;
            tx_start_q <= 1'b0;
            grant_q    <= '0;
            done_q     <= '0;
            err_q      <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rr_q       <= rr_d;
            owner_q    <= owner_d;
            tx_in_q    <= tx_in_d;
            tx_start_q <= tx_start_d;
            grant_q    <= grant_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign grant    = grant_q;
    assign done     = done_q;
    assign err      = err_q;
    assign tx_in    = tx_in_q;
    assign tx_start = tx_start_q;
    assign owner    = owner_q;
    assign active   = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: table of frames through a scripted uart_tx
// busy model, plus hand-written timeout, collision, external-busy and reset cases.
module tb_uart_tx_arbiter;

    localparam int unsigned N_REQ  = 4;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned ST_TO  = 64;
    localparam int unsigned GUARD  = 2;

    logic        clk;
    logic        reset;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  grant, done, err;
    logic [7:0]  tx_in;
    logic        tx_start;
    logic        tx_busy;
    logic        active;
    logic [1:0]  owner;

    int n_vec  = 0;
    int n_fail = 0;

    uart_tx_arbiter #(
        .N_REQ(N_REQ), .DATA_W(DATA_W), .START_TIMEOUT(ST_TO), .GUARD_CYCLES(GUARD)
    ) dut (
        .clk(clk), .reset(reset), .req(req), .req_data(req_data),
        .grant(grant), .done(done), .err(err), .tx_in(tx_in),
        .tx_start(tx_start), .tx_busy(tx_busy), .active(active), .owner(owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  req;
        logic [31:0] data;
        logic [3:0]  exp_grant;
        logic [7:0]  exp_tx;
        logic [1:0]  exp_owner;
    } vec_t;

    vec_t vecs[11];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // One frame: busy rises 2 cycles after start and stays high for 20 cycles.
    task automatic do_frame(input vec_t v);
        req = v.req;
        req_data = v.data;
        tick();
        chk("grant", 32'(grant), 32'(v.exp_grant));
        chk("tx_in", 32'(tx_in), 32'(v.exp_tx));
        chk("owner", 32'(owner), 32'(v.exp_owner));
        chk("tx_start_rise", 32'(tx_start), 32'd1);
        req = v.req & ~v.exp_grant;
        tick();
        chk("grant_one_cycle", 32'(grant), 32'd0);
        chk("tx_start_hold1", 32'(tx_start), 32'd1);
        tick();
        chk("tx_start_hold2", 32'(tx_start), 32'd1);
        tx_busy = 1'b1;
        tick();
        chk("tx_start_drop", 32'(tx_start), 32'd0);
        chk("active_drain", 32'(active), 32'd1);
        repeat (19) begin
            tick();
            chk("done_early", 32'(done | err), 32'd0);
        end
        chk("tx_in_stable", 32'(tx_in), 32'(v.exp_tx));
        tx_busy = 1'b0;
        tick();
        chk("done_pulse", 32'(done), 32'(v.exp_grant));
        chk("err_none", 32'(err), 32'd0);
        tick();
        chk("done_one_cycle", 32'(done), 32'd0);
        chk("active_gap", 32'(active), 32'd1);
        tick();
        chk("active_idle", 32'(active), 32'd0);
    endtask

    initial begin
        int cnt;
        logic seen_err;

        vecs[0]  = '{4'b1111, 32'h6B657669, 4'b0001, 8'h69, 2'd0};
        vecs[1]  = '{4'b1110, 32'h6B657669, 4'b0010, 8'h76, 2'd1};
        vecs[2]  = '{4'b1100, 32'h6B657669, 4'b0100, 8'h65, 2'd2};
        vecs[3]  = '{4'b1000, 32'h6B657669, 4'b1000, 8'h6B, 2'd3};
        vecs[4]  = '{4'b0010, 32'h00005600, 4'b0010, 8'h56, 2'd1};
        vecs[5]  = '{4'b0100, 32'h12345678, 4'b0100, 8'h34, 2'd2};
        vecs[6]  = '{4'b0101, 32'h12345678, 4'b0001, 8'h78, 2'd0};
        vecs[7]  = '{4'b0101, 32'h12345678, 4'b0100, 8'h34, 2'd2};
        vecs[8]  = '{4'b0011, 32'hDEADBEEF, 4'b0001, 8'hEF, 2'd0};
        vecs[9]  = '{4'b0011, 32'hDEADBEEF, 4'b0010, 8'hBE, 2'd1};
        vecs[10] = '{4'b1001, 32'hDEADBEEF, 4'b1000, 8'hDE, 2'd3};

        reset = 1'b1; req = '0; req_data = '0; tx_busy = 1'b0;
        #3 reset = 1'b0;
        #3;
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_done_err", 32'(done | err), 32'd0);
        chk("rst_tx_start", 32'(tx_start), 32'd0);
        chk("rst_tx_in", 32'(tx_in), 32'd0);
        chk("rst_active", 32'(active), 32'd0);
        chk("rst_owner", 32'(owner), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b1;
        tick();

        for (int i = 0; i < 11; i++) do_frame(vecs[i]);
        req = '0;

        // start timeout with busy held low
        req = 4'b1000;
        tick();
        chk("to_grant", 32'(grant), 32'b1000);
        req = '0;
        cnt = 1;
        seen_err = 1'b0;
        for (int k = 0; k < 200; k++) begin
            tick();
            if (tx_start !== 1'b1) break;
            if (err !== 4'b0000) seen_err = 1'b1;
            cnt++;
        end
        chk("to_start_len", 32'(cnt), 32'(ST_TO));
        chk("to_no_early_err", 32'(seen_err), 32'd0);
        chk("to_err", 32'(err), 32'b1000);
        chk("to_no_done", 32'(done), 32'd0);
        tick();
        chk("to_err_one", 32'(err), 32'd0);
        chk("to_gap_active", 32'(active), 32'd1);
        tick();
        chk("to_idle", 32'(active), 32'd0);
        do_frame('{4'b0001, 32'hA5A5A5C3, 4'b0001, 8'hC3, 2'd0});

        // busy rises on the terminal-count cycle
        req = 4'b0100;
        tick();
        chk("col_grant", 32'(grant), 32'b0100);
        req = '0;
        seen_err = 1'b0;
        repeat (ST_TO - 1) begin
            tick();
            if (err !== 4'b0000) seen_err = 1'b1;
        end
        chk("col_start_high", 32'(tx_start), 32'd1);
        tx_busy = 1'b1;
        tick();
        chk("col_no_err", 32'(err | {3'b0, seen_err}), 32'd0);
        chk("col_start_drop", 32'(tx_start), 32'd0);
        chk("col_drain", 32'(active), 32'd1);
        repeat (3) tick();
        tx_busy = 1'b0;
        tick();
        chk("col_done", 32'(done), 32'b0100);
        tick();
        tick();
        chk("col_idle", 32'(active), 32'd0);

        // external busy in IDLE blocks granting
        tx_busy = 1'b1;
        req = 4'b0010;
        repeat (4) begin
            tick();
            chk("ext_no_grant", 32'({active, grant}), 32'd0);
        end
        tx_busy = 1'b0;
        tick();
        chk("ext_grant", 32'(grant), 32'b0010);
        req = '0;
        tx_busy = 1'b1;
        tick();
        chk("ext_drain", 32'(tx_start), 32'd0);
        tx_busy = 1'b0;
        tick();
        chk("ext_done", 32'(done), 32'b0010);
        tick();
        tick();
        chk("ext_idle", 32'(active), 32'd0);

        // reset mid-LAUNCH, then rr pointer must be back at 0
        req = 4'b0100;
        tick();
        chk("rl_grant", 32'(grant), 32'b0100);
        req = 4'b1001;
        tick();
        #2 reset = 1'b0;
        #1;
        chk("rl_tx_start", 32'(tx_start), 32'd0);
        chk("rl_active", 32'(active), 32'd0);
        chk("rl_pulses", 32'({grant, done, err}), 32'd0);
        chk("rl_owner", 32'(owner), 32'd0);
        #2 reset = 1'b1;
        tick();
        chk("rl_grant_rr0", 32'(grant), 32'b0001);
        req = '0;
        tx_busy = 1'b1;
        tick();
        chk("rd_in_drain", 32'({active, tx_start}), 32'b10);
        #2 reset = 1'b0;
        #1;
        chk("rd_active", 32'(active), 32'd0);
        chk("rd_outs", 32'({tx_start, grant, done, err}), 32'd0);
        tx_busy = 1'b0;
        #2 reset = 1'b1;
        tick();
        chk("rd_no_done", 32'(done | err), 32'd0);
        tick();
        chk("rd_no_done2", 32'({active, done, err}), 32'd0);
        req = 4'b1001;
        tick();
        chk("rd_grant_rr0", 32'(grant), 32'b0001);
        req = '0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
